// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Front-end scheduler for the byte-serial memory controller. Each requester
// (instruction fetch, load, committed store) has one pending slot. The
// arbiter hands one request at a time to the controller. It then routes the
// controller's completion back to the owner as a one-cycle done pulse, with
// read data on rdata.
//
// Priority when choosing a winner: store, then load, then fetch. A pending
// fetch that has lost STARVE_LIMIT arbitrations wins the next one. A
// misbranch flush drops fetch/load traffic. A fetch/load already handed to
// the controller runs to completion, but its result is discarded.
// Committed stores are never affected by flush.
//
// Handshake semantics: every *_req, *_done, mc_valid and mc_done is a
// single-cycle pulse. A request pulse is sampled on the edge where it is
// high and rdy=1, together with its payload. A requester must not pulse
// again before its done. mc_valid opens exactly one controller transaction.
// The mc_* payload stays stable until the controller answers with mc_done.
// No further mc_valid is issued until then.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   rdy             global enable; low freezes all state and outputs
//   flush           misbranch: cancel fetch/load traffic
//   if_req/if_addr  fetch request (always a 4-byte read)
//   ld_req/...      load request: address, size in bytes, sign-extend flag
//   st_req/...      committed store: address, size in bytes, LSB-aligned data
//   if_done, ld_done, st_done   completion pulses to the owner
//   rdata           read result, valid with if_done/ld_done
//   mc_valid/mc_*   transaction start and payload to the controller
//   mc_done/mc_rdata controller completion and read data
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_size,
    input  logic              ld_signed,
    output logic              ld_done,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [2:0]        st_size,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mc_valid,
    output logic              mc_we,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [2:0]        mc_size,
    output logic              mc_signed,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LD   = 2'd2;
    localparam logic [1:0] OWN_ST   = 2'd3;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [1:0]        state;
    logic [1:0]        owner;
    logic              drop;
    logic [CNT_W-1:0]  starve_cnt;

    logic              pend_if;
    logic [ADDR_W-1:0] if_addr_q;
    logic              pend_ld;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [2:0]        ld_size_q;
    logic              ld_signed_q;
    logic              pend_st;
    logic [ADDR_W-1:0] st_addr_q;
    logic [2:0]        st_size_q;
    logic [DATA_W-1:0] st_data_q;

    logic              if_live;
    logic              ld_live;
    logic              starved;
    logic              spec_owner;
    logic              kill;
    logic [1:0]        sel;

    // A flush on the selection edge already cancels pending fetch/load, so
    // those slots must not take part in that edge's arbitration.
    assign if_live    = pend_if & ~flush;
    assign ld_live    = pend_ld & ~flush;
    assign starved    = if_live && (starve_cnt == LIMIT_C);
    assign spec_owner = (owner == OWN_IF) || (owner == OWN_LD);
    // Result is thrown away when the owner was flushed earlier or is being
    // flushed on the very edge that consumes mc_done.
    assign kill       = drop | (flush & spec_owner);

    always_comb begin
        sel = OWN_NONE;
        if (starved)      sel = OWN_IF;
        else if (pend_st) sel = OWN_ST;
        else if (ld_live) sel = OWN_LD;
        else if (if_live) sel = OWN_IF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= OWN_NONE;
            drop        <= 1'b0;
            starve_cnt  <= '0;
            pend_if     <= 1'b0;
            if_addr_q   <= '0;
            pend_ld     <= 1'b0;
            ld_addr_q   <= '0;
            ld_size_q   <= '0;
            ld_signed_q <= 1'b0;
            pend_st     <= 1'b0;
            st_addr_q   <= '0;
            st_size_q   <= '0;
            st_data_q   <= '0;
            if_done     <= 1'b0;
            ld_done     <= 1'b0;
            st_done     <= 1'b0;
            rdata       <= '0;
            mc_valid    <= 1'b0;
            mc_we       <= 1'b0;
            mc_addr     <= '0;
            mc_size     <= '0;
            mc_signed   <= 1'b0;
            mc_wdata    <= '0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            mc_valid <= 1'b0;

            // Starvation bookkeeping: count grants lost by a waiting fetch.
            if (flush) begin
                starve_cnt <= '0;
            end else if (state == S_IDLE && sel != OWN_NONE) begin
                if (sel == OWN_IF)
                    starve_cnt <= '0;
                else if (pend_if && starve_cnt != LIMIT_C)
                    starve_cnt <= starve_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    drop <= 1'b0;
                    if (sel != OWN_NONE) begin
                        owner    <= sel;
                        state    <= S_GRANT;
                        mc_valid <= 1'b1;
                        case (sel)
                            OWN_IF: begin
                                pend_if   <= 1'b0;
                                mc_we     <= 1'b0;
                                mc_addr   <= if_addr_q;
                                mc_size   <= 3'd4;
                                mc_signed <= 1'b0;
                                mc_wdata  <= '0;
                            end
                            OWN_LD: begin
                                pend_ld   <= 1'b0;
                                mc_we     <= 1'b0;
                                mc_addr   <= ld_addr_q;
                                mc_size   <= ld_size_q;
                                mc_signed <= ld_signed_q;
                                mc_wdata  <= '0;
                            end
                            default: begin
                                pend_st   <= 1'b0;
                                mc_we     <= 1'b1;
                                mc_addr   <= st_addr_q;
                                mc_size   <= st_size_q;
                                mc_signed <= 1'b0;
                                mc_wdata  <= st_data_q;
                            end
                        endcase
                    end
                end
                S_GRANT: begin
                    state <= S_BUSY;
                    if (flush && spec_owner) drop <= 1'b1;
                end
                S_BUSY: begin
                    if (flush && spec_owner) drop <= 1'b1;
                    if (mc_done) begin
                        state <= S_IDLE;
                        owner <= OWN_NONE;
                        drop  <= 1'b0;
                        if (!kill) begin
                            case (owner)
                                OWN_IF: begin
                                    if_done <= 1'b1;
                                    rdata   <= mc_rdata;
                                end
                                OWN_LD: begin
                                    ld_done <= 1'b1;
                                    rdata   <= mc_rdata;
                                end
                                OWN_ST:  st_done <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Capture new requests after the grant logic so a capture is never
            // lost to a slot clear. Flush discards same-edge fetch/load pulses
            // and empties their slots; stores are always kept.
            if (flush) begin
                pend_if <= 1'b0;
                pend_ld <= 1'b0;
            end else begin
                if (if_req) begin
                    pend_if   <= 1'b1;
                    if_addr_q <= if_addr;
                end
                if (ld_req) begin
                    pend_ld     <= 1'b1;
                    ld_addr_q   <= ld_addr;
                    ld_size_q   <= ld_size;
                    ld_signed_q <= ld_signed;
                end
            end
            if (st_req) begin
                pend_st   <= 1'b1;
                st_addr_q <= st_addr;
                st_size_q <= st_size;
                st_data_q <= st_data;
            end
        end
    end

endmodule
